// File: rtl/penta_pkg.sv
// Shared key definitions for the five-button front panel.
// Also used by the menu FSM, so the constants live here.
package penta_pkg;

  localparam int KEY_W    = 3;
  localparam int NUM_KEYS = 5;

  localparam logic [KEY_W-1:0] KEY0 = 3'd0;
  localparam logic [KEY_W-1:0] KEY1 = 3'd1;
  localparam logic [KEY_W-1:0] KEY2 = 3'd2;
  localparam logic [KEY_W-1:0] KEY3 = 3'd3;
  localparam logic [KEY_W-1:0] KEY4 = 3'd4;

  // Number of press pulses that are high in one cycle.
  function automatic logic [2:0] count_presses(input logic [NUM_KEYS-1:0] x);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n = n + {2'b00, x[i]};
    end
    return n;
  endfunction

  // Key code of the lowest pulse that is high; only meaningful when exactly one is set.
  function automatic logic [KEY_W-1:0] encode_key(input logic [NUM_KEYS-1:0] x);
    logic [KEY_W-1:0] code;
    code = KEY0;
    if (x[4]) code = KEY4;
    if (x[3]) code = KEY3;
    if (x[2]) code = KEY2;
    if (x[1]) code = KEY1;
    if (x[0]) code = KEY0;
    return code;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head-of-queue output.
// rd_data holds its last value while the FIFO is empty.
module sync_fifo #(
  parameter int  WIDTH  = 3,
  parameter int  DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic              pop_ok;
  logic              push_ok;
  logic [WIDTH-1:0]  head_next;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push & (~full | pop_ok);

  // Pick the value the head register should show after this edge.
  always_comb begin
    head_next   = rd_data;
    rd_ptr_next = rd_ptr + ADDR_W'(pop_ok);
    if (push_ok && ((count == '0) || ((count == (ADDR_W + 1)'(1)) && pop_ok))) begin
      // Incoming entry becomes the head directly.
      head_next = push_data;
    end else if (pop_ok && (count > (ADDR_W + 1)'(1))) begin
      head_next = mem[rd_ptr_next];
    end
  end

  // Storage array write; contents need no reset because rd_data is reset separately.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_ptr_next;
      rd_data <= head_next;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/penta_key_queue.sv
// Encodes single-cycle debounced key presses into 3-bit codes and queues them
// for downstream control logic.
//
// Handshake: key_valid is high while a code is queued and key_code is the head.
// A transfer happens on a rising edge where key_valid & key_ready; key_valid and
// key_code never change while key_valid & !key_ready. key_ready only feeds
// next-state logic, and the press inputs never reach an output combinationally.
module penta_key_queue
  import penta_pkg::*;
#(
  parameter int  DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              X0_deb,
  input  logic              X1_deb,
  input  logic              X2_deb,
  input  logic              X3_deb,
  input  logic              X4_deb,
  input  logic              key_ready,
  input  logic              flag_clr,
  output logic              key_valid,
  output logic [KEY_W-1:0]  key_code,
  output logic [ADDR_W:0]   key_count,
  output logic              overflow,
  output logic              collision
);

  logic [NUM_KEYS-1:0] presses;
  logic [2:0]          press_cnt;
  logic                push_req;
  logic                multi_press;
  logic [KEY_W-1:0]    press_code;
  logic                pop;
  logic                push_acc;
  logic                fifo_full;
  logic                fifo_empty;
  logic                overflow_set;

  assign presses     = {X4_deb, X3_deb, X2_deb, X1_deb, X0_deb};
  assign press_cnt   = count_presses(presses);
  assign push_req    = (press_cnt == 3'd1);
  assign multi_press = (press_cnt > 3'd1);
  assign press_code  = encode_key(presses);

  assign key_valid    = ~fifo_empty;
  assign pop          = key_valid & key_ready;
  assign push_acc     = push_req & (~fifo_full | pop);
  assign overflow_set = push_req & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (sysclk),
    .reset     (reset),
    .push      (push_acc),
    .push_data (press_code),
    .pop       (pop),
    .rd_data   (key_code),
    .count     (key_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      overflow  <= overflow_set | (overflow & ~flag_clr);
      collision <= multi_press  | (collision & ~flag_clr);
    end
  end

endmodule

// File: tb/tb_penta_key_queue.sv
// Self-checking bench for penta_key_queue with a scoreboard of expected key codes.
module tb_penta_key_queue;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [4:0] x_vec;
  logic       key_ready;
  logic       flag_clr;
  logic       key_valid;
  logic [2:0] key_code;
  logic [2:0] key_count;
  logic       overflow;
  logic       collision;

  logic [2:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  penta_key_queue #(.DEPTH(4)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .X0_deb    (x_vec[0]),
    .X1_deb    (x_vec[1]),
    .X2_deb    (x_vec[2]),
    .X3_deb    (x_vec[3]),
    .X4_deb    (x_vec[4]),
    .key_ready (key_ready),
    .flag_clr  (flag_clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_count (key_count),
    .overflow  (overflow),
    .collision (collision)
  );

  // Clock
  always #5 sysclk = ~sysclk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Single-cycle press on key k.
  task automatic press(input int k);
    x_vec = 5'b00001 << k;
    tick();
    x_vec = '0;
  endtask

  // Pop every expected entry, comparing each against the scoreboard.
  task automatic drain(input string name);
    int budget;
    logic [2:0] exp_code;
    budget = 20;
    key_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      exp_code = exp_q.pop_front();
      checks++;
      if (key_valid !== 1'b1 || key_code !== exp_code) begin
        errors++;
        $display("FAIL %s_pop: valid=%b code=%0d, required valid=1 code=%0d", name, key_valid, key_code, exp_code);
      end
      tick();
      budget--;
    end
    key_ready = 1'b0;
    checks++;
    if (budget == 0 && exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_drain_budget: %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (key_valid !== 1'b0 || key_count !== 3'd0) begin
      errors++;
      $display("FAIL %s_empty: valid=%b count=%0d, required valid=0 count=0", name, key_valid, key_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (key_valid !== 1'b0 || key_code !== 3'd0 || key_count !== 3'd0 || overflow !== 1'b0 || collision !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%b code=%0d count=%0d ovf=%b col=%b, required all 0",
               key_valid, key_code, key_count, overflow, collision);
    end
  endtask

  task automatic test_single_hold();
    exp_q.push_back(3'd2);
    press(2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== 3'd2 || key_count !== 3'd1) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b code=%0d count=%0d, required valid=1 code=2 count=1",
                 i, key_valid, key_code, key_count);
      end
      tick();
    end
    drain("hold");
  endtask

  task automatic test_order();
    exp_q.push_back(3'd0); press(0);
    exp_q.push_back(3'd4); press(4);
    exp_q.push_back(3'd1); press(1);
    checks++;
    if (key_count !== 3'd3) begin
      errors++;
      $display("FAIL order_count: count=%0d, required 3", key_count);
    end
    drain("order");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(3'd3);
      press(3);
    end
    checks++;
    if (key_count !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_full: count=%0d ovf=%b, required count=4 ovf=1", key_count, overflow);
    end
    drain("overflow");
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: ovf=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [2:0] exp_code;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(3'd3);
      press(3);
    end
    // Press and pop on the same edge while full.
    x_vec = 5'b00010;
    key_ready = 1'b1;
    exp_code = exp_q.pop_front();
    exp_q.push_back(3'd1);
    checks++;
    if (key_valid !== 1'b1 || key_code !== exp_code) begin
      errors++;
      $display("FAIL fullpp_pop: valid=%b code=%0d, required valid=1 code=%0d", key_valid, key_code, exp_code);
    end
    tick();
    x_vec = '0;
    key_ready = 1'b0;
    checks++;
    if (key_count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpp_count: count=%0d ovf=%b, required count=4 ovf=0", key_count, overflow);
    end
    drain("fullpp");
  endtask

  task automatic test_collision();
    x_vec = 5'b01001;
    tick();
    x_vec = '0;
    checks++;
    if (key_count !== 3'd0 || key_valid !== 1'b0 || collision !== 1'b1) begin
      errors++;
      $display("FAIL collision_set: count=%0d valid=%b col=%b, required count=0 valid=0 col=1",
               key_count, key_valid, collision);
    end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    checks++;
    if (collision !== 1'b0) begin
      errors++;
      $display("FAIL collision_clear: col=%b, required 0", collision);
    end
    // Clear and a new collision in the same cycle: the flag stays set.
    flag_clr = 1'b1;
    x_vec = 5'b10100;
    tick();
    flag_clr = 1'b0;
    x_vec = '0;
    checks++;
    if (collision !== 1'b1) begin
      errors++;
      $display("FAIL collision_set_wins: col=%b, required 1", collision);
    end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    press(2);
    press(0);
    checks++;
    if (key_count !== 3'd2) begin
      errors++;
      $display("FAIL midreset_prefill: count=%0d, required 2", key_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (key_valid !== 1'b0 || key_count !== 3'd0 || overflow !== 1'b0 || collision !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values: valid=%b count=%0d ovf=%b col=%b, required all 0",
               key_valid, key_count, overflow, collision);
    end
    exp_q.push_back(3'd4);
    press(4);
    drain("midreset");
  endtask

  // Random single presses and ready, with an occupancy model deciding acceptance.
  task automatic test_random();
    int model_cnt;
    int k;
    logic pop_m;
    logic [2:0] exp_code;
    model_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      k = $urandom_range(0, 7);
      key_ready = ($urandom_range(0, 2) == 0);
      x_vec = (k < 5) ? (5'b00001 << k) : 5'b00000;
      pop_m = (model_cnt > 0) && key_ready;
      checks++;
      if (key_count !== 3'(model_cnt) || key_valid !== (model_cnt > 0)) begin
        errors++;
        $display("FAIL rand_state_c%0d: count=%0d valid=%b, required count=%0d valid=%b",
                 c, key_count, key_valid, model_cnt, (model_cnt > 0));
      end
      if (pop_m) begin
        exp_code = exp_q.pop_front();
        checks++;
        if (key_code !== exp_code) begin
          errors++;
          $display("FAIL rand_pop_c%0d: code=%0d, required %0d", c, key_code, exp_code);
        end
        model_cnt--;
      end
      if (k < 5 && model_cnt < 4) begin
        exp_q.push_back(3'(k));
        model_cnt++;
      end
      tick();
    end
    x_vec = '0;
    drain("rand");
  endtask

  initial begin
    reset = 1'b1;
    x_vec = '0;
    key_ready = 1'b0;
    flag_clr = 1'b0;
    test_reset();
    test_single_hold();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/penta_key_queue.md
Name: penta_key_queue

Overview:
- Consumer side of the five-button debounce interface: accepts the five single-cycle debounced press pulses, encodes each press into a 3-bit key code and buffers it in a small FIFO.
- Presents the codes to downstream control logic (menu FSM, mode selector) over a valid/ready handshake, so presses arriving while the consumer is busy are not lost.
- Sits directly after the debouncer in the same sysclk domain.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- sysclk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- X0_deb  input  1  single-cycle press pulse, key 0 (code 3'd0)
- X1_deb  input  1  press pulse, key 1 (code 3'd1)
- X2_deb  input  1  press pulse, key 2 (code 3'd2)
- X3_deb  input  1  press pulse, key 3 (code 3'd3)
- X4_deb  input  1  press pulse, key 4 (code 3'd4)
- key_ready  input  1  downstream accepts head entry this cycle
- flag_clr  input  1  clears sticky flags
- key_valid  output  1  FIFO non-empty, key_code valid
- key_code  output  3  head-of-queue key code
- key_count  output  ADDR_W+1  entries currently stored
- overflow  output  1  sticky: a press was dropped because FIFO full
- collision  output  1  sticky: more than one X*_deb high in the same cycle

Behaviour:
- Clock and reset: one clock, sysclk; reset is synchronous and active-high.
- Reset values: all outputs 0; key_code 3'd0; pointers 0.
- Reset mid-operation discards all queued entries.
- Press detection:
  - push_req when exactly one X*_deb is high in a cycle.
  - If 2 or more are high: no push, collision <= 1.
  - Pulses are sampled every cycle; an input held high for N cycles produces N pushes. The debouncer guarantees 1-cycle pulses.
- Pop: occurs when key_valid & key_ready. The head advances on that edge.
- Push acceptance:
  - A push is accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the press is dropped and overflow <= 1; stored contents are unchanged.
- Count update:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - key_count never exceeds DEPTH.
- Latency:
  - A press into an empty FIFO gives key_valid = 1 on the next cycle, with the code registered.
  - A push and pop in the same cycle on an empty FIFO is impossible, because key_valid = 0.
- Output stability: key_code and key_valid are held stable while key_valid & !key_ready.
- key_code when empty: holds its last value. Consumers must qualify it with key_valid.
- Pointer wrap: read and write pointers are ADDR_W bits and wrap modulo DEPTH. Full/empty are decided from the count register.
- Sticky flags:
  - overflow and collision stay set until flag_clr or reset.
  - If flag_clr and a new set event occur in the same cycle, the set wins (flag = 1).
- No combinational path from X*_deb to any output; key_ready affects only the next-state logic.

Decomposition:
- Shared package penta_pkg:
  - KEY_W = 3.
  - Key code constants KEY0..KEY4 (3'd0..3'd4).
  - NUM_KEYS = 5.
  - Also reused by the menu FSM.
- One sub-module, sync_fifo:
  - Parameterised by WIDTH and DEPTH; synchronous active-high reset.
  - Ports: push, push_data, pop, rd_data, count, full, empty.
- penta_key_queue itself holds the one-hot check, encoder, accept logic and sticky flags.

Test Plan:
- Reset, then a 1-cycle pulse on X2_deb with key_ready = 0 -> next cycle key_valid = 1, key_code = 3'd2, key_count = 1. Both remain held for 10 cycles.
- Pulses on X0, X4, X1 in 3 separate cycles, then key_ready = 1 -> codes 0, 4, 1 popped in order on consecutive cycles; key_valid = 0 after the third pop; key_count returns to 0.
- DEPTH = 4 with key_ready = 0: 5 single pulses (X3 x5) -> key_count = 4, overflow = 1, and the queue drains exactly 4 x code 3.
- FIFO full, and in the same cycle a pulse on X1 with key_ready = 1 -> push accepted, key_count stays 4, overflow stays 0; the last drained code is 1.
- X0_deb and X3_deb high in the same cycle -> no entry, key_count = 0, collision = 1. Then flag_clr for 1 cycle -> collision = 0.
- Queue holding 2 entries, assert reset for 1 cycle -> key_valid = 0, key_count = 0, flags = 0. Then the next X4 pulse -> key_code = 4 as the first entry.
